// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one combinational WIDTH-bit ALU between two requesters:
//   port 0 is the main execute path, port 1 the branch/compare helper.
//   Requesters are granted one at a time with round-robin priority. The
//   granted op and operands are registered and driven into the ALU for one
//   ISSUE cycle. The ALU result and zero flag are then captured and returned
//   on a valid/ready response channel.
//
// Ports
//   clk, reset              : clock; synchronous active-high reset
//   reqN_valid/op/a/b       : request from requester N (N = 0, 1)
//   reqN_ready              : request N accepted this cycle (IDLE only)
//   rspN_valid/data/zero    : captured result for requester N
//   rspN_ready              : requester N consumes the result
//   alu_op/alu_a/alu_b      : registered drive into the ALU
//   alu_result/alu_zero     : combinational ALU outputs
//   busy                    : arbiter is not in IDLE
// ---------------------------------------------------------------------------

// Per-port response holding register. It loads on capture and drops valid
// on the consumer handshake. Data and flag are held after the handshake.
module alu_share_rsp_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture,
    input  logic             clear,
    input  logic [WIDTH-1:0] result,
    input  logic             zero,
    output logic             vld,
    output logic [WIDTH-1:0] data,
    output logic             zflag
);
    always_ff @(posedge clk) begin
        if (reset) begin
            vld   <= 1'b0;
            data  <= '0;
            zflag <= 1'b0;
        end else if (capture) begin
            vld   <= 1'b1;
            data  <= result;
            zflag <= zero;
        end else if (clear) begin
            vld   <= 1'b0;
        end
    end
endmodule

module alu_share_arbiter #(
    parameter int               WIDTH   = 8,
    parameter int               OPW     = 4,
    parameter logic [OPW-1:0]   IDLE_OP = 4'b0010
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_zero,

    input  logic             req1_valid,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_zero,

    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic             busy
);
    localparam int NPORT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t state;
    logic   ptr;     // requester that wins the next contention
    logic   owner;   // requester whose op is in flight
    logic   grant;
    logic   accept;

    logic [NPORT-1:0]            req_valid;
    logic [NPORT-1:0]            req_ready;
    logic [NPORT-1:0][OPW-1:0]   req_op;
    logic [NPORT-1:0][WIDTH-1:0] req_a;
    logic [NPORT-1:0][WIDTH-1:0] req_b;
    logic [NPORT-1:0]            rsp_valid;
    logic [NPORT-1:0]            rsp_ready;
    logic [NPORT-1:0][WIDTH-1:0] rsp_data;
    logic [NPORT-1:0]            rsp_zero;
    logic [NPORT-1:0]            capture;
    logic [NPORT-1:0]            clear;

    assign req_valid = {req1_valid, req0_valid};
    assign req_op    = {req1_op, req0_op};
    assign req_a     = {req1_a, req0_a};
    assign req_b     = {req1_b, req0_b};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_data  = rsp_data[0];
    assign rsp1_data  = rsp_data[1];
    assign rsp0_zero  = rsp_zero[0];
    assign rsp1_zero  = rsp_zero[1];

    // Port 1 wins when it is the only requester, or when both request and
    // the pointer favours it. Otherwise port 0 wins.
    assign grant  = req_valid[1] & (~req_valid[0] | ptr);
    assign accept = |req_ready;
    assign busy   = (state != ST_IDLE);

    genvar p;
    generate
        for (p = 0; p < NPORT; p++) begin : g_port
            assign req_ready[p] = (state == ST_IDLE) && req_valid[p] && (grant == 1'(p));
            assign capture[p]   = (state == ST_ISSUE) && (owner == 1'(p));
            assign clear[p]     = (state == ST_RESP) && (owner == 1'(p)) && rsp_ready[p];

            alu_share_rsp_slot #(.WIDTH(WIDTH)) u_slot (
                .clk     (clk),
                .reset   (reset),
                .capture (capture[p]),
                .clear   (clear[p]),
                .result  (alu_result),
                .zero    (alu_zero),
                .vld     (rsp_valid[p]),
                .data    (rsp_data[p]),
                .zflag   (rsp_zero[p])
            );
        end
    endgenerate

    // The ALU drive registers double as the latched request. They are loaded
    // on acceptance, so they hold the op for exactly the ISSUE cycle. They
    // return to the idle drive when ISSUE ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            ptr    <= 1'b0;
            owner  <= 1'b0;
            alu_op <= IDLE_OP;
            alu_a  <= '0;
            alu_b  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner  <= grant;
                        alu_op <= req_op[grant];
                        alu_a  <= req_a[grant];
                        alu_b  <= req_b[grant];
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    alu_op <= IDLE_OP;
                    alu_a  <= '0;
                    alu_b  <= '0;
                    state  <= ST_RESP;
                end
                ST_RESP: begin
                    // Hand priority to the other side so that neither side starves.
                    if (rsp_ready[owner]) begin
                        ptr   <= ~owner;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
    localparam int W = 8;
    localparam int O = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [O-1:0] req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp0_data, rsp1_data;
    logic         rsp0_zero, rsp1_zero;
    logic [O-1:0] alu_op;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic         alu_zero, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Transaction-level reference: one op in flight, accepted at cycle m_acc.
    bit         m_busy;
    int         m_acc;
    bit         m_own, m_ptr;
    logic [3:0] m_op;
    logic [7:0] m_a, m_b;
    logic [7:0] m_rd [2];
    bit         m_rz [2];
    bit         hs [2];
    int         obs_grants[$];
    logic [7:0] held;

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_alu(logic [3:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return (a < b) ? 8'd1 : 8'd0;
            4'b1100: return ~(a | b);
            4'b1111: return ~a;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = ref_alu(alu_op, alu_a, alu_b);
    assign alu_zero   = (alu_result == 8'd0);

    alu_share_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check at the falling edge, advance the model, and return
    // 1 time unit after the next rising edge.
    task automatic step();
        bit v [2];
        bit rr [2];
        bit rdy [2];
        bit issue, resp;
        @(negedge clk);
        hs[0] = 0; hs[1] = 0;
        if (reset) begin
            m_busy = 0; m_ptr = 0;
            m_rd[0] = 8'd0; m_rd[1] = 8'd0; m_rz[0] = 0; m_rz[1] = 0;
        end else begin
            v[0] = req0_valid; v[1] = req1_valid;
            rr[0] = rsp0_ready; rr[1] = rsp1_ready;
            for (int n = 0; n < 2; n++)
                rdy[n] = !m_busy && v[n] && (!v[1-n] || (m_ptr == n[0]));
            issue = m_busy && (cyc == m_acc + 1);
            resp  = m_busy && (cyc >= m_acc + 2);
            chk("req0_ready", req0_ready, rdy[0]);
            chk("req1_ready", req1_ready, rdy[1]);
            chk("rsp0_valid", rsp0_valid, resp && !m_own);
            chk("rsp1_valid", rsp1_valid, resp && m_own);
            chk("rsp0_data", rsp0_data, m_rd[0]);
            chk("rsp0_zero", rsp0_zero, m_rz[0]);
            chk("rsp1_data", rsp1_data, m_rd[1]);
            chk("rsp1_zero", rsp1_zero, m_rz[1]);
            chk("busy", busy, m_busy);
            chk("alu_op", alu_op, issue ? m_op : 4'b0010);
            chk("alu_a", alu_a, issue ? m_a : 8'd0);
            chk("alu_b", alu_b, issue ? m_b : 8'd0);
            if (req0_valid && req0_ready) obs_grants.push_back(0);
            if (req1_valid && req1_ready) obs_grants.push_back(1);
            if (issue) begin
                m_rd[m_own] = ref_alu(m_op, m_a, m_b);
                m_rz[m_own] = (m_rd[m_own] == 8'd0);
            end
            if (resp && rr[m_own]) begin
                m_busy = 0;
                m_ptr  = !m_own;
            end else if (!m_busy) begin
                for (int n = 0; n < 2; n++) if (rdy[n]) begin
                    m_busy = 1; m_acc = cyc; m_own = n[0]; hs[n] = 1;
                    m_op = n ? req1_op : req0_op;
                    m_a  = n ? req1_a  : req0_a;
                    m_b  = n ? req1_b  : req0_b;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        step(); step();
        reset = 0;
        step();

        // Single ADD on port 0.
        req0_valid = 1; req0_op = 4'b0010; req0_a = 8'h05; req0_b = 8'h03;
        #1 chk("add_ready0", req0_ready, 1'b1);
        step();
        req0_valid = 0;
        chk("add_op", alu_op, 4'b0010);
        chk("add_a", alu_a, 8'h05);
        chk("add_b", alu_b, 8'h03);
        step();
        chk("add_rvld", rsp0_valid, 1'b1);
        chk("add_data", rsp0_data, 8'h08);
        chk("add_zero", rsp0_zero, 1'b0);
        step();

        // Idle ALU drive.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_op", alu_op, 4'b0010);
            chk("idle_busy", busy, 1'b0);
        end

        // Contention from reset: grants alternate, starting with port 0.
        reset = 1; step(); reset = 0;
        obs_grants.delete();
        req0_valid = 1; req0_op = 4'b0010; req0_a = 8'h01; req0_b = 8'h02;
        req1_valid = 1; req1_op = 4'b0110; req1_a = 8'h07; req1_b = 8'h07;
        for (int i = 0; i < 12; i++) step();
        chk("rr_count", obs_grants.size(), 4);
        for (int i = 0; i < 4 && i < obs_grants.size(); i++)
            chk("rr_order", obs_grants[i], i % 2);
        chk("sub_zero", rsp1_zero, 1'b1);
        chk("sub_data", rsp1_data, 8'h00);
        req0_valid = 0; req1_valid = 0;
        step(); step();

        // Response backpressure on port 0 while port 1 waits.
        req0_valid = 1; req0_op = 4'b0001; req0_a = 8'h30; req0_b = 8'h03;
        step();
        req0_valid = 0;
        req1_valid = 1; req1_op = 4'b1111; req1_a = 8'hF0; req1_b = 8'h00;
        rsp0_ready = 0;
        step();
        held = rsp0_data;
        for (int i = 0; i < 4; i++) begin
            chk("bp_rvld", rsp0_valid, 1'b1);
            chk("bp_data", rsp0_data, held);
            chk("bp_rdy1", req1_ready, 1'b0);
            step();
        end
        chk("bp_held", held, 8'h33);
        rsp0_ready = 1;
        step();
        chk("bp_grant1", req1_ready, 1'b1);
        step();
        req1_valid = 0;
        // Op pass-through of NOT.
        chk("not_op", alu_op, 4'b1111);
        step();
        chk("not_data", rsp1_data, 8'h0F);
        step();

        // Reset in ISSUE: pointer returns to port 0.
        req0_valid = 1; req0_op = 4'b0000; req0_a = 8'hAA; req0_b = 8'h0F;
        step();
        req0_valid = 0;
        step(); step();
        req0_valid = 1; req1_valid = 1;
        #1 chk("pre_rst_grant1", req1_ready, 1'b1);
        step();
        reset = 1;
        step();
        reset = 0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_rvld1", rsp1_valid, 1'b0);
        chk("rst_grant0", req0_ready, 1'b1);
        step();
        req0_valid = 0; req1_valid = 0;
        step(); step(); step();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            if (!req0_valid || hs[0] || $urandom_range(0, 15) == 0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_op = 4'($urandom_range(0, 15));
                req0_a = 8'($urandom); req0_b = 8'($urandom);
            end
            if (!req1_valid || hs[1] || $urandom_range(0, 15) == 0) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_op = 4'($urandom_range(0, 15));
                req1_a = 8'($urandom); req1_b = 8'($urandom);
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
